intmul_folded: RTL and testbench
================================

# intmul_folded

Folded, handshaked unsigned integer multiplier. It computes C = A·B by cycling one group of B tiles per cycle through a bank of DSP-tile multipliers and accumulating the shifted row products. It is the area-scaled successor to the fully parallel tile multiplier. The modular-multiplier datapath uses it where DSP count matters more than throughput. Tile widths come from the shared DSP definitions: `DSP_A_U` and `DSP_B_U` for the operands, `DSP_M_U` for the product.

## Interface
Parameters:
- W_A, 64, width of operand A.
- W_B, 64, width of operand B.
- B_PER_CYC, 1, B tiles consumed per iteration. Range 1..N_B.
- FF_MUL, 1, register stage after the tile multipliers (0 or 1).
- TAG_W, 8, width of the sideband tag carried with each operation.

Derived values:
- N_A = ceil(W_A/DSP_A_U).
- N_B = ceil(W_B/DSP_B_U).
- N_IT = ceil(N_B/B_PER_CYC).
- L = N_IT + FF_MUL.

Ports:
- clk  in  1  clock. All state changes on the rising edge.
- rst  in  1  reset. Asynchronous, active-low.
- in_valid  in  1  operands and tag are valid.
- in_ready  out  1  block can accept an operation.
- A  in  W_A  multiplicand.
- B  in  W_B  multiplier.
- in_tag  in  TAG_W  user tag.
- out_valid  out  1  result is valid.
- out_ready  in  1  downstream accepts the result.
- C  out  W_A+W_B  product.
- out_tag  out  TAG_W  tag captured with the operands.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- **IDLE:**
  - in_ready = 1.
  - On in_valid & in_ready: capture A, B and in_tag; clear the accumulator and the iteration counter it; go to RUN.
- **RUN:**
  - Each cycle, multiply all N_A A-tiles by B tiles it·B_PER_CYC .. it·B_PER_CYC+B_PER_CYC−1.
  - Tiles at index ≥ N_B are treated as zero.
  - The last tile of A and of B is zero-extended.
  - Row product for tile j is Σ_i A_i·B_j shifted by i·DSP_A_U + j·DSP_B_U.
  - Accumulate into a W_A+W_B accumulator, truncating any carries above bit W_A+W_B−1. The exact product always fits, so truncation never loses information.
  - it increments each cycle.
  - After the step with it = N_IT−1, go to DRAIN if FF_MUL = 1, else go to DONE.
- **DRAIN** (FF_MUL = 1 only): for one cycle, add the final registered product, then go to DONE.
  - With FF_MUL = 1, each step's product is registered first and added one cycle later.
- **DONE:**
  - out_valid = 1.
  - C and out_tag hold steady until out_valid & out_ready; the block then returns to IDLE.
- in_ready is 0 in RUN, DRAIN and DONE. There is no overlap: a new operation cannot be accepted in the DONE-exit cycle.
- Operand and tag registers hold their values across the whole operation. Changes on A, B or in_tag after acceptance have no effect.

## Timing
- Acceptance edge is t.
- Accumulator updates occur on edges t+1 .. t+L.
- out_valid is first high in the cycle following edge t+L.
- Next acceptance is possible no earlier than one cycle after the out_ready handshake.
- Throughput is one result per L+2 cycles when out_ready is held high.
- Reset values while rst = 0:
  - state IDLE
  - in_ready = 0 (forced low during reset)
  - out_valid = 0
  - C = 0, out_tag = 0
  - accumulator, counter and product register all zero.
- rst deasserting: in_ready goes to 1 from the first cycle after release.
- rst asserted mid-RUN or mid-DONE aborts the operation immediately. The result is discarded and no out_valid pulse appears.
- out_ready low in DONE stalls indefinitely; all outputs stay stable.
- in_valid high outside IDLE is ignored. The same operands must be re-presented later.
- No combinational path from in_valid or out_ready to any output except through state. in_ready and out_valid are decoded from state only (plus rst).

## Structure
- Shared package intmul_pkg:
  - Functions ceil_div and n_tiles(W, U).
  - State enum type for IDLE/RUN/DRAIN/DONE.
  - Localparam helpers for N_A, N_B, N_IT.
- One sub-module, intmul_row_step.
  - Combinational: takes A and a B_PER_CYC-tile slice plus the tile base index.
  - Produces the shifted (W_A+W_B)-wide partial sum for the step.
  - Contains the N_A·B_PER_CYC tile multipliers.
- Top level holds:
  - FSM
  - iteration counter, width clog2(N_IT)+1
  - operand, tag and product registers
  - accumulator.

## Test plan
- W_A=W_B=64, B_PER_CYC=1, FF_MUL=1: A=B=2^64−1, tag 0x5A. Required: C=2^128−2^65+1, out_tag=0x5A, out_valid exactly L edges after acceptance.
- A=0x1, B=0xDEADBEEF_CAFEBABE, then A=0, B=2^64−1. Required: C=0xDEADBEEF_CAFEBABE, then C=0.
- Sweep B_PER_CYC ∈ {1, 2, N_B} and FF_MUL ∈ {0, 1} on 1000 random operand pairs. Required: C matches the reference product; latency equals ceil(N_B/B_PER_CYC)+FF_MUL.
- W_A=17, W_B=53 (partial last tiles), A=2^17−1, B=2^53−1. Required: C=(2^17−1)(2^53−1).
- Hold out_ready=0 for 20 cycles in DONE while toggling in_valid and A. Required: C, out_tag and out_valid stable; in_ready=0; the first operation completes on release.
- Assert rst mid-RUN (cycle t+2). Required:
  - out_valid stays 0 and C=0.
  - in_ready returns to 1 after release.
  - A fresh operation then completes correctly.

Source files
------------

// File: rtl/intmul_pkg.sv
// Shared definitions for the folded tile multiplier: DSP tile geometry,
// FSM state encoding and tile-count helpers.
package intmul_pkg;

  // Unsigned operand widths of one DSP tile multiplier and its product width
  localparam int DSP_A_U = 26;
  localparam int DSP_B_U = 17;
  localparam int DSP_M_U = DSP_A_U + DSP_B_U;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

  function automatic int n_tiles(input int w, input int u);
    return ceil_div(w, u);
  endfunction

  function automatic int n_a(input int w_a);
    return n_tiles(w_a, DSP_A_U);
  endfunction

  function automatic int n_b(input int w_b);
    return n_tiles(w_b, DSP_B_U);
  endfunction

  function automatic int n_it(input int w_b, input int b_per_cyc);
    return ceil_div(n_b(w_b), b_per_cyc);
  endfunction

endpackage

// File: rtl/intmul_row_step.sv
// One folded step: all A tiles times a group of B tiles, each tile product
// shifted to its weight and summed into a (W_A+W_B)-wide partial sum.
module intmul_row_step
  import intmul_pkg::*;
#(
  parameter int W_A       = 64,
  parameter int W_B       = 64,
  parameter int B_PER_CYC = 1,
  parameter int BASE_W    = 4
) (
  input  logic [W_A-1:0]               a,
  input  logic [B_PER_CYC*DSP_B_U-1:0] b_slice,
  input  logic [BASE_W-1:0]            base,
  output logic [W_A+W_B-1:0]           sum
);

  localparam int N_A  = n_a(W_A);
  localparam int W_C  = W_A + W_B;
  localparam int N_TL = N_A * B_PER_CYC;

  logic [N_A*DSP_A_U-1:0]       a_pad;
  logic [N_TL-1:0][DSP_M_U-1:0] prod;

  // last A tile is zero-extended; B padding is done by the caller
  assign a_pad = (N_A*DSP_A_U)'(a);

  genvar gi, gj;
  generate
    for (gj = 0; gj < B_PER_CYC; gj++) begin : g_b
      for (gi = 0; gi < N_A; gi++) begin : g_a
        assign prod[gj*N_A+gi] = DSP_M_U'(a_pad[gi*DSP_A_U +: DSP_A_U])
                               * DSP_M_U'(b_slice[gj*DSP_B_U +: DSP_B_U]);
      end
    end
  endgenerate

  // weight each tile product by its A and absolute B tile position; bits
  // shifted past the top are dropped since the full product fits in W_C
  always_comb begin
    sum = '0;
    for (int j = 0; j < B_PER_CYC; j++)
      for (int i = 0; i < N_A; i++)
        sum = sum + (W_C'(prod[j*N_A+i]) << (i*DSP_A_U + (int'(base) + j)*DSP_B_U));
  end

endmodule

// File: rtl/intmul_folded.sv
// Folded handshaked unsigned multiplier: one group of B tiles per cycle
// through the tile bank, row products accumulated into C.
module intmul_folded
  import intmul_pkg::*;
#(
  parameter int W_A       = 64,
  parameter int W_B       = 64,
  parameter int B_PER_CYC = 1,
  parameter int FF_MUL    = 1,
  parameter int TAG_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W_A-1:0]     A,
  input  logic [W_B-1:0]     B,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W_A+W_B-1:0] C,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int N_IT   = n_it(W_B, B_PER_CYC);
  localparam int IT_W   = $clog2(N_IT) + 1;
  localparam int W_C    = W_A + W_B;
  localparam int SL_W   = B_PER_CYC * DSP_B_U;
  localparam int BP_W   = N_IT * SL_W;
  localparam int BASE_W = $clog2(N_IT*B_PER_CYC + 1);

  state_e            state_q, state_d;
  logic [W_A-1:0]    a_q;
  logic [W_B-1:0]    b_q;
  logic [TAG_W-1:0]  tag_q;
  logic [IT_W-1:0]   it;
  logic [W_C-1:0]    acc, prod_q, row;
  logic [BP_W-1:0]   b_pad;
  logic [SL_W-1:0]   b_slice;
  logic [BASE_W-1:0] base;
  logic              accept, last_it;

  assign last_it = (it == IT_W'(N_IT - 1));

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_RUN;
      S_RUN:   if (last_it) state_d = (FF_MUL != 0) ? S_DRAIN : S_DONE;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // handshake outputs decoded from state; in_ready held low during reset
  always_comb begin
    in_ready  = rst && (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    accept    = in_valid && in_ready;
  end

  // pad B with zero tiles so every group index past N_B multiplies by zero
  assign b_pad = BP_W'(b_q);
  assign base  = BASE_W'(int'(it) * B_PER_CYC);

  // select the B tile group for the current iteration
  always_comb begin
    b_slice = '0;
    for (int k = 0; k < N_IT; k++)
      if (it == IT_W'(k)) b_slice = b_pad[k*SL_W +: SL_W];
  end

  intmul_row_step #(
    .W_A       (W_A),
    .W_B       (W_B),
    .B_PER_CYC (B_PER_CYC),
    .BASE_W    (BASE_W)
  ) u_row (
    .a       (a_q),
    .b_slice (b_slice),
    .base    (base),
    .sum     (row)
  );

  // operand capture, iteration count and accumulation; with the product
  // register the accumulator adds the previous step's row, so the first
  // RUN edge adds the cleared register and DRAIN adds the last row
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q    <= '0;
      b_q    <= '0;
      tag_q  <= '0;
      it     <= '0;
      acc    <= '0;
      prod_q <= '0;
    end else if (accept) begin
      a_q    <= A;
      b_q    <= B;
      tag_q  <= in_tag;
      it     <= '0;
      acc    <= '0;
      prod_q <= '0;
    end else if (state_q == S_RUN) begin
      it     <= it + 1'b1;
      prod_q <= row;
      acc    <= acc + ((FF_MUL != 0) ? prod_q : row);
    end else if (state_q == S_DRAIN) begin
      acc    <= acc + prod_q;
    end
  end

  assign C       = acc;
  assign out_tag = tag_q;

endmodule

// File: tb/tb_intmul_folded.sv
// Scoreboard bench: six 64x64 instances sweeping B_PER_CYC {1,2,4} x
// FF_MUL {1,0} plus one 17x53 instance, all sharing the input side.
module tb_intmul_folded;

  localparam int ND = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [63:0] A = '0;
  logic [63:0] B = '0;
  logic [7:0]  in_tag = '0;

  logic [ND-1:0]        ir, ov;
  logic [ND-1:0][127:0] cc;
  logic [ND-1:0][7:0]   tg;
  logic [69:0]          c6;

  logic [127:0] sb [ND][$];
  logic [7:0]   tag_sb [$];

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 6; g++) begin : g_dut
      intmul_folded #(
        .W_A(64), .W_B(64),
        .B_PER_CYC((g/2 == 0) ? 1 : ((g/2 == 1) ? 2 : 4)),
        .FF_MUL((g%2 == 0) ? 1 : 0),
        .TAG_W(8)
      ) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[g]),
        .A(A), .B(B), .in_tag(in_tag), .out_valid(ov[g]),
        .out_ready(out_ready), .C(cc[g]), .out_tag(tg[g])
      );
    end
  endgenerate

  intmul_folded #(
    .W_A(17), .W_B(53), .B_PER_CYC(1), .FF_MUL(1), .TAG_W(8)
  ) u_odd (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[6]),
    .A(A[16:0]), .B(B[52:0]), .in_tag(in_tag), .out_valid(ov[6]),
    .out_ready(out_ready), .C(c6), .out_tag(tg[6])
  );
  assign cc[6] = 128'(c6);

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // latency: ceil(N_B/B_PER_CYC) + FF_MUL, N_B = 4 for both widths used
  function automatic int lat_exp(input int d);
    int bpc, ff;
    if (d == 6) return 4 + 1;
    bpc = (d/2 == 0) ? 1 : ((d/2 == 1) ? 2 : 4);
    ff  = (d%2 == 0) ? 1 : 0;
    return (4 + bpc - 1) / bpc + ff;
  endfunction

  task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                        input logic [7:0] t, input bit stall);
    int lat [ND];
    logic [127:0] e;
    logic [7:0] et;
    @(negedge clk);
    chk("in_ready_idle", 128'(&ir), 128'(1));
    A = a; B = b; in_tag = t; in_valid = 1'b1;
    for (int d = 0; d < 6; d++) sb[d].push_back(128'(a) * 128'(b));
    sb[6].push_back(128'(a[16:0]) * 128'(b[52:0]));
    tag_sb.push_back(t);
    @(posedge clk); #1;
    // operand changes after acceptance must not matter
    in_valid = 1'b0; A = {$urandom, $urandom}; B = {$urandom, $urandom}; in_tag = 8'($urandom);
    for (int d = 0; d < ND; d++) lat[d] = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      for (int d = 0; d < ND; d++) if (lat[d] < 0 && ov[d]) lat[d] = k;
      if (&ov) break;
    end
    for (int d = 0; d < ND; d++) chk($sformatf("latency[%0d]", d), 128'(lat[d]), 128'(lat_exp(d)));
    if (stall) begin
      for (int k = 0; k < 20; k++) begin
        in_valid = ~in_valid; A = {$urandom, $urandom};
        @(posedge clk); #1;
        for (int d = 0; d < ND; d++) begin
          chk($sformatf("stall_c[%0d]", d), cc[d], sb[d][0]);
          chk($sformatf("stall_tag[%0d]", d), 128'(tg[d]), 128'(tag_sb[0]));
        end
        chk("stall_valid", 128'(ov), 128'({ND{1'b1}}));
        chk("stall_ready", 128'(ir), 128'(0));
      end
      in_valid = 1'b0;
    end
    et = tag_sb.pop_front();
    for (int d = 0; d < ND; d++) begin
      e = sb[d].pop_front();
      chk($sformatf("C[%0d]", d), cc[d], e);
      chk($sformatf("tag[%0d]", d), 128'(tg[d]), 128'(et));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("valid_after_hs", 128'(ov), 128'(0));
    chk("ready_after_hs", 128'(ir), 128'({ND{1'b1}}));
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_in_ready", 128'(ir), 128'(0));
    chk("rst_out_valid", 128'(ov), 128'(0));
    chk("rst_C0", cc[0], 128'(0));
    chk("rst_C6", cc[6], 128'(0));
    chk("rst_tag0", 128'(tg[0]), 128'(0));
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", 128'(ir), 128'({ND{1'b1}}));

    // all-ones operands, then directed identity / zero cases
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'h5A, 1'b0);
    chk("all_ones_const", cc[0], 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    run_op(64'h1, 64'hDEAD_BEEF_CAFE_BABE, 8'h11, 1'b0);
    chk("ident_const", cc[0], 128'hDEAD_BEEF_CAFE_BABE);
    run_op(64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h22, 1'b0);
    chk("zero_const", cc[0], 128'h0);

    // output stall with in_valid/A toggling
    run_op({$urandom, $urandom}, {$urandom, $urandom}, 8'hC3, 1'b1);

    // reset mid-RUN at t+2
    @(negedge clk);
    A = 64'h1234_5678_9ABC_DEF0; B = 64'h0FED_CBA9_8765_4321; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b0;
    #1;
    chk("abort_valid", 128'(ov), 128'(0));
    chk("abort_C0", cc[0], 128'(0));
    chk("abort_ready", 128'(ir), 128'(0));
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("abort_hold_valid", 128'(ov), 128'(0));
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_rel_ready", 128'(ir), 128'({ND{1'b1}}));
    chk("abort_rel_valid", 128'(ov), 128'(0));
    chk("abort_rel_C0", cc[0], 128'(0));
    run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 8'h77, 1'b0);

    // random sweep
    for (int n = 0; n < 1000; n++)
      run_op({$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom), 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
